// File: rtl/color_converter.sv
// One output channel of an RGB -> YCbCr (BT.601, 8-bit) converter.
// color_out = clamp(((R_MULT*R + G_MULT*G + B_MULT*B + 128) >>> 8) + BIAS, 0, 255)
// Three-stage pipeline; every stage advances only on an enabled edge.
// Optional feature macro: COLOR_CONVERTER_SAT_EN (saturate instead of wrap in S3).
module color_converter #(
    parameter int R_MULT = 66,
    parameter int G_MULT = 129,
    parameter int B_MULT = 25,
    parameter int BIAS   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic [7:0] color_out
);

    // Coefficients fit in 10-bit signed (-512..511).
    localparam logic signed [9:0] R_COEF = R_MULT[9:0];
    localparam logic signed [9:0] G_COEF = G_MULT[9:0];
    localparam logic signed [9:0] B_COEF = B_MULT[9:0];
    localparam logic signed [15:0] BIAS_EXT = BIAS[15:0];

    logic signed [18:0] prod_r_d, prod_g_d, prod_b_d;
    logic signed [18:0] prod_r_q, prod_g_q, prod_b_q;
    logic signed [21:0] sum_d, sum_q;
    logic signed [15:0] t_val;
    logic [7:0]         color_d;

    // S1: zero-extend each sample to 9-bit signed and scale by its coefficient.
    always_comb begin
        prod_r_d = 19'($signed({1'b0, red_in}))   * 19'(R_COEF);
        prod_g_d = 19'($signed({1'b0, green_in})) * 19'(G_COEF);
        prod_b_d = 19'($signed({1'b0, blue_in}))  * 19'(B_COEF);
    end

    // S2: accumulate the three products with the rounding constant.
    always_comb begin
        sum_d = 22'(prod_r_q) + 22'(prod_g_q) + 22'(prod_b_q) + 22'sd128;
    end

    // S3: floor-shift, add bias, then limit to one byte.
    always_comb begin
        t_val = 16'(sum_q >>> 8) + BIAS_EXT;
`ifdef COLOR_CONVERTER_SAT_EN
        if (t_val < 16'sd0) begin
            color_d = 8'd0;
        end else if (t_val > 16'sd255) begin
            color_d = 8'd255;
        end else begin
            color_d = t_val[7:0];
        end
`else
        color_d = t_val[7:0];
`endif
    end

    // Pipeline registers: reset wins, otherwise load only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_r_q  <= '0;
            prod_g_q  <= '0;
            prod_b_q  <= '0;
            sum_q     <= '0;
            color_out <= '0;
        end else if (enable) begin
            prod_r_q  <= prod_r_d;
            prod_g_q  <= prod_g_d;
            prod_b_q  <= prod_b_d;
            sum_q     <= sum_d;
            color_out <= color_d;
        end
    end

endmodule

// File: tb/tb_color_converter.sv
// Directed bench for color_converter: Y/Cb/Cr coefficient sets, streaming,
// stall behaviour and out-of-range handling (saturate or wrap per build macro).
module tb_color_converter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] red_in, green_in, blue_in;
    logic [7:0] y_out, cb_out, cr_out, hi_out, lo_out;

    int tests;
    int fails;

    color_converter #(.R_MULT(66), .G_MULT(129), .B_MULT(25), .BIAS(16)) u_y (
        .clk(clk), .reset(reset), .enable(enable),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .color_out(y_out)
    );

    color_converter #(.R_MULT(-38), .G_MULT(-74), .B_MULT(112), .BIAS(128)) u_cb (
        .clk(clk), .reset(reset), .enable(enable),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .color_out(cb_out)
    );

    color_converter #(.R_MULT(112), .G_MULT(-94), .B_MULT(-18), .BIAS(128)) u_cr (
        .clk(clk), .reset(reset), .enable(enable),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .color_out(cr_out)
    );

    color_converter #(.R_MULT(255), .G_MULT(255), .B_MULT(255), .BIAS(0)) u_hi (
        .clk(clk), .reset(reset), .enable(enable),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .color_out(hi_out)
    );

    color_converter #(.R_MULT(-512), .G_MULT(0), .B_MULT(0), .BIAS(0)) u_lo (
        .clk(clk), .reset(reset), .enable(enable),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .color_out(lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef COLOR_CONVERTER_SAT_EN
    localparam logic [7:0] EXP_HI = 8'd255;
    localparam logic [7:0] EXP_LO = 8'd0;
`else
    localparam logic [7:0] EXP_HI = 8'd250;
    localparam logic [7:0] EXP_LO = 8'd2;
`endif

    // black, red, blue, white, yellow, green
    logic [7:0] px_r [6] = '{8'd0, 8'd255, 8'd0,   8'd255, 8'd255, 8'd0};
    logic [7:0] px_g [6] = '{8'd0, 8'd0,   8'd0,   8'd255, 8'd255, 8'd255};
    logic [7:0] px_b [6] = '{8'd0, 8'd0,   8'd255, 8'd255, 8'd0,   8'd0};
    logic [7:0] exp_y  [6] = '{8'd16,  8'd82,  8'd41,  8'd235, 8'd210, 8'd144};
    logic [7:0] exp_cb [6] = '{8'd128, 8'd90,  8'd240, 8'd128, 8'd16,  8'd54};
    logic [7:0] exp_cr [6] = '{8'd128, 8'd240, 8'd110, 8'd128, 8'd146, 8'd34};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        red_in   = r;
        green_in = g;
        blue_in  = b;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        enable = 1'b1;
        set_px(8'd255, 8'd255, 8'd255);

        // Reset with enable high and live inputs: everything stays cleared.
        repeat (3) tick();
        chk("reset_y",  y_out,  8'd0);
        chk("reset_cb", cb_out, 8'd0);
        chk("reset_cr", cr_out, 8'd0);
        chk("reset_hi", hi_out, 8'd0);
        chk("reset_lo", lo_out, 8'd0);
        reset = 1'b0;

        // Back-to-back stream; result of pixel k shows after its third enabled edge.
        for (int i = 0; i < 8; i++) begin
            if (i < 6) set_px(px_r[i], px_g[i], px_b[i]);
            else       set_px(8'd0, 8'd0, 8'd0);
            tick();
            if (i == 0) begin
                // Cleared S2 flows out as bias only.
                chk("post_reset_hi", hi_out, 8'd0);
                chk("post_reset_lo", lo_out, 8'd0);
                chk("post_reset_y",  y_out,  8'd16);
                chk("post_reset_cb", cb_out, 8'd128);
            end
            if (i >= 2) begin
                chk($sformatf("y_px%0d",  i - 2), y_out,  exp_y[i - 2]);
                chk($sformatf("cb_px%0d", i - 2), cb_out, exp_cb[i - 2]);
                chk($sformatf("cr_px%0d", i - 2), cr_out, exp_cr[i - 2]);
                if (i - 2 == 3) begin
                    chk("range_hi", hi_out, EXP_HI);
                    chk("range_lo", lo_out, EXP_LO);
                end
            end
        end

        // Stall with red and blue in flight; the output must hold black's result.
        set_px(8'd255, 8'd0, 8'd0);
        tick();
        set_px(8'd0, 8'd0, 8'd255);
        tick();
        enable = 1'b0;
        set_px(8'd255, 8'd255, 8'd255);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("stall%0d_y",  i), y_out,  8'd16);
            chk($sformatf("stall%0d_cr", i), cr_out, 8'd128);
        end

        // Resume: red, blue, then the black fed on the resume edge, in order.
        enable = 1'b1;
        set_px(8'd0, 8'd0, 8'd0);
        tick();
        chk("resume_red_y",  y_out,  8'd82);
        chk("resume_red_cr", cr_out, 8'd240);
        tick();
        chk("resume_blue_y",  y_out,  8'd41);
        chk("resume_blue_cr", cr_out, 8'd110);
        tick();
        chk("resume_black_y",  y_out,  8'd16);
        chk("resume_black_cr", cr_out, 8'd128);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
